// File: rtl/spi_cmd_decoder_if.sv
// Command-side handshake bundle of the SPI command decoder.
//   cmd_valid   decoded command pending
//   cmd_ready   consumer accepts command when valid & ready
//   cmd_onehot  one-hot opcode index, stable while cmd_valid
//   cmd_data    payload, first received byte in the MSBs
//   cmd_err     1-clk pulse: bad opcode, short frame or checksum fail
//   cmd_ovr     1-clk pulse: frame completed while a command was still pending
//   busy        frame in progress (chip select asserted, synchronised)
// Modports: master = decoder (produces commands), slave = command executor.
interface spi_cmd_decoder_if #(
    parameter int NUM_CMDS   = 4,
    parameter int DATA_BYTES = 2
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [NUM_CMDS-1:0]     cmd_onehot;
    logic [DATA_BYTES*8-1:0] cmd_data;
    logic                    cmd_err;
    logic                    cmd_ovr;
    logic                    busy;

    modport master (
        output cmd_valid, cmd_onehot, cmd_data, cmd_err, cmd_ovr, busy,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_onehot, cmd_data, cmd_err, cmd_ovr, busy,
        output cmd_ready
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI mode-0 slave front end: deframes opcode + payload frames from the external
// master into decoded commands with a valid/ready handshake.
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   spi_sclk/spi_cs_n/spi_mosi raw SPI pins (sclk idle low, sampled on rising edge, MSB first)
//   cmd                        spi_cmd_decoder_if.master (valid/ready, onehot, data, err, ovr, busy)
// Build option: define SPI_CMD_CHECKSUM_EN to expect a trailing XOR checksum byte
// (XOR of opcode and all payload bytes) after the payload.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | chip select high, counters cleared
// ST_OPCODE  | shifting the 8-bit opcode
// ST_PAYLOAD | shifting DATA_BYTES payload bytes
// ST_CHECK   | shifting the checksum byte (checksum build only)
// ST_DONE    | frame complete, further bits ignored until cs_n high
// ST_ERROR   | bad opcode or checksum, further bits ignored until cs_n high
module spi_cmd_decoder #(
    parameter int         NUM_CMDS    = 4,
    parameter logic [7:0] CMD_BASE    = 8'h41,
    parameter int         DATA_BYTES  = 2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    spi_cmd_decoder_if.master cmd
);

    localparam int DW  = DATA_BYTES * 8;
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s, sclk_d, sclk_rise;

    logic [2:0]          bit_cnt;
    logic [BCW-1:0]      byte_cnt;
    logic [7:0]          shift_reg;
    logic [DW-1:0]       data_reg;
    logic [NUM_CMDS-1:0] onehot_reg;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    logic [7:0]          byte_next;
    logic [7:0]          opcode_diff;
    logic [NUM_CMDS-1:0] onehot_next;
    logic                opcode_ok;
    logic [DW-1:0]       data_next;
    logic                bit_last;
    logic                shift_en;
    logic                err_set;
    logic                complete;

    logic                valid_q, err_q, ovr_q;
    logic [NUM_CMDS-1:0] onehot_q;
    logic [DW-1:0]       data_q;

    // Synchronisers; cs_n resets to the deasserted level so reset never looks like a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;

    // Value the shift register takes on this edge; used for decisions on the final bit of a byte.
    assign byte_next   = {shift_reg[6:0], mosi_s};
    assign opcode_diff = byte_next - CMD_BASE;
    assign data_next   = (data_reg << 8) | DW'(byte_next);
    assign bit_last    = (bit_cnt == 3'd7);

    // An opcode below CMD_BASE wraps to a large difference, but is rejected explicitly anyway.
    always_comb begin
        onehot_next = '0;
        for (int k = 0; k < NUM_CMDS; k++) begin
            onehot_next[k] = (opcode_diff == 8'(k));
        end
    end

    assign opcode_ok = (byte_next >= CMD_BASE) && (|onehot_next);

    assign shift_en = sclk_rise && !cs_s &&
                      ((state == ST_OPCODE) || (state == ST_PAYLOAD) || (state == ST_CHECK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cs_s) begin
                    state_next = ST_OPCODE;
                end
            end
            ST_OPCODE: begin
                if (cs_s) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_last) begin
                    if (opcode_ok) begin
                        state_next = ST_PAYLOAD;
                    end else begin
                        state_next = ST_ERROR;
                        err_set    = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (cs_s) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_last && (byte_cnt == LAST_BYTE)) begin
`ifdef SPI_CMD_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
                    complete   = 1'b1;
`endif
                end
            end
`ifdef SPI_CMD_CHECKSUM_EN
            ST_CHECK: begin
                if (cs_s) begin
                    state_next = ST_IDLE;
                    err_set    = 1'b1;
                end else if (sclk_rise && bit_last) begin
                    if (byte_next == csum) begin
                        state_next = ST_DONE;
                        complete   = 1'b1;
                    end else begin
                        state_next = ST_ERROR;
                        err_set    = 1'b1;
                    end
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (cs_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath; everything is wiped while idle or as soon as cs_n is seen high,
    // so a partial frame never leaks into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            data_reg   <= '0;
            onehot_reg <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if ((state == ST_IDLE) || cs_s) begin
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            data_reg   <= '0;
            onehot_reg <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if (shift_en) begin
            shift_reg <= byte_next;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_last) begin
`ifdef SPI_CMD_CHECKSUM_EN
                csum <= csum ^ byte_next;
`endif
                if (state == ST_OPCODE) begin
                    onehot_reg <= onehot_next;
                end
                if (state == ST_PAYLOAD) begin
                    data_reg <= data_next;
                    byte_cnt <= byte_cnt + BCW'(1);
                end
            end
        end
    end

    // Output handshake. A completion in the same cycle as an accept replaces the
    // accepted command; a completion while one is stuck pending is dropped as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            onehot_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            err_q <= err_set;
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || cmd.cmd_ready) begin
                    valid_q  <= 1'b1;
                    onehot_q <= onehot_reg;
`ifdef SPI_CMD_CHECKSUM_EN
                    data_q   <= data_reg;
`else
                    data_q   <= data_next;
`endif
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && cmd.cmd_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign cmd.cmd_valid  = valid_q;
    assign cmd.cmd_onehot = onehot_q;
    assign cmd.cmd_data   = data_q;
    assign cmd.cmd_err    = err_q;
    assign cmd.cmd_ovr    = ovr_q;
    assign cmd.busy       = (state != ST_IDLE);

endmodule
